// File: rtl/issue_queue_dual_pkg.sv
// Shared constants for the dual-lane decode-to-issue queue: lane count, bus width
// and the per-lane valid encodings used on enqueue and dequeue.
package issue_queue_dual_pkg;
  localparam int IQ_LANES        = 2;
  localparam int DS_TO_IS_BUS_WD = 256;

  localparam logic [1:0] LANE_NONE = 2'b00;
  localparam logic [1:0] LANE_LO   = 2'b01;
  localparam logic [1:0] LANE_HI   = 2'b10;
  localparam logic [1:0] LANE_BOTH = 2'b11;

  function automatic logic [1:0] lane_cnt(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction
endpackage

// File: rtl/issue_queue_dual_iq_storage.sv
// DEPTH x DATA_W entry array with two write ports and two asynchronous read ports.
// Callers guarantee the two write ports never target the same slot in a cycle.
module iq_storage
  import issue_queue_dual_pkg::*;
#(
  parameter int DATA_W = DS_TO_IS_BUS_WD,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                               clk,
  input  logic [IQ_LANES-1:0]                we,
  input  logic [IQ_LANES-1:0][AW-1:0]        waddr,
  input  logic [IQ_LANES-1:0][DATA_W-1:0]    wdata,
  input  logic [IQ_LANES-1:0][AW-1:0]        raddr,
  output logic [IQ_LANES-1:0][DATA_W-1:0]    rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Payload only; validity lives in the pointer/count logic, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we[0] && waddr[0] == AW'(i)) mem[i] <= wdata[0];
      if (we[1] && waddr[1] == AW'(i)) mem[i] <= wdata[1];
    end
  end

  for (genvar p = 0; p < IQ_LANES; p++) begin : g_rd
    assign rdata[p] = mem[raddr[p]];
  end
endmodule

// File: rtl/issue_queue_dual.sv
// In-order dual-lane launch queue between decode and issue: up to two enqueues and
// two dequeues per cycle, single-cycle flush, registered protocol-error pulse.
module issue_queue_dual
  import issue_queue_dual_pkg::*;
#(
  parameter int DATA_W = DS_TO_IS_BUS_WD,
  parameter int DEPTH  = 8,
  parameter int AF_TH  = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic [1:0]                 in_valid_i,
  input  logic [2*DATA_W-1:0]        in_data_i,
  output logic                       allowin_o,
  output logic [1:0]                 out_valid_o,
  output logic [2*DATA_W-1:0]        out_data_o,
  input  logic [1:0]                 deq_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       almost_full_o,
  output logic                       error_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head_r, tail_r;
  logic [CW-1:0] count_r;
  logic          error_r;

  logic [IQ_LANES-1:0][DATA_W-1:0] lane_data, wdata, rdata;
  logic [IQ_LANES-1:0][AW-1:0]     waddr, raddr;
  logic [IQ_LANES-1:0]             we;

  logic       enq_ok, deq_bad_enc, deq_over, err_next;
  logic [1:0] n_enq, n_deq_req, n_deq;

  assign lane_data = in_data_i;

  assign allowin_o     = count_r <= CW'(DEPTH - 2);
  assign almost_full_o = count_r >= CW'(AF_TH);
  assign out_valid_o   = {count_r >= CW'(2), count_r != '0};
  assign count_o       = count_r;
  assign error_o       = error_r;
  assign out_data_o    = rdata;

  assign enq_ok = allowin_o && !flush_i;
  assign n_enq  = enq_ok ? lane_cnt(in_valid_i) : 2'd0;

  assign deq_bad_enc = deq_i == LANE_HI;
  assign n_deq_req   = (deq_i == LANE_BOTH) ? 2'd2 : (deq_i == LANE_LO) ? 2'd1 : 2'd0;
  assign deq_over    = CW'(n_deq_req) > count_r;
  assign n_deq       = (deq_bad_enc || deq_over) ? 2'd0 : n_deq_req;

  assign err_next = ((in_valid_i != LANE_NONE) && !allowin_o) || deq_bad_enc || deq_over;

  // A lone lane1 request is compacted onto write port 0 so the queue stays dense.
  assign we[0]    = enq_ok && (in_valid_i != LANE_NONE);
  assign we[1]    = enq_ok && (in_valid_i == LANE_BOTH);
  assign wdata[0] = in_valid_i[0] ? lane_data[0] : lane_data[1];
  assign wdata[1] = lane_data[1];

  for (genvar l = 0; l < IQ_LANES; l++) begin : g_lane
    assign waddr[l] = tail_r + AW'(l);
    assign raddr[l] = head_r + AW'(l);
  end

  iq_storage #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_storage (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (flush_i) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      head_r  <= head_r + AW'(n_deq);
      tail_r  <= tail_r + AW'(n_enq);
      count_r <= count_r + CW'(n_enq) - CW'(n_deq);
    end
  end

  // Error reporting is independent of flush: a bad request in a flush cycle still pulses.
  always_ff @(posedge clk) begin
    if (reset) error_r <= 1'b0;
    else       error_r <= err_next;
  end
endmodule

// File: tb/tb_issue_queue_dual.sv
// Directed bench for issue_queue_dual: queue-based reference model checked every
// cycle, plus literal expectations at the scenario boundaries.
module tb_issue_queue_dual;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AF    = 6;

  logic            clk = 1'b0;
  logic            reset, flush_i;
  logic [1:0]      in_valid_i, deq_i;
  logic [2*DW-1:0] in_data_i;
  logic            allowin_o, almost_full_o, error_o;
  logic [1:0]      out_valid_o;
  logic [2*DW-1:0] out_data_o;
  logic [3:0]      count_o;

  issue_queue_dual #(.DATA_W(DW), .DEPTH(DEPTH), .AF_TH(AF)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .allowin_o(allowin_o),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .deq_i(deq_i),
    .count_o(count_o), .almost_full_o(almost_full_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  int          tests = 0, fails = 0;
  logic [DW-1:0] mq[$];
  bit          m_err = 1'b0;
  bit          chk_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("cmp_count",   64'(count_o), 64'(mq.size()));
      check("cmp_allowin", 64'(allowin_o), 64'((DEPTH - mq.size()) >= 2));
      check("cmp_afull",   64'(almost_full_o), 64'(mq.size() >= AF));
      check("cmp_valid",   64'(out_valid_o), {62'd0, mq.size() >= 2, mq.size() >= 1});
      check("cmp_error",   64'(error_o), 64'(m_err));
      if (mq.size() >= 1) check("cmp_data0", 64'(out_data_o[DW-1:0]), 64'(mq[0]));
      if (mq.size() >= 2) check("cmp_data1", 64'(out_data_o[2*DW-1:DW]), 64'(mq[1]));
    end
  end

  // One clock of stimulus; the model computes the post-edge queue from the rules.
  task automatic step(input logic [1:0] v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [1:0] d, input logic f);
    int sz;
    int nd;
    bit alw;
    bit err;
    logic [DW-1:0] nq[$];
    sz  = mq.size();
    alw = (DEPTH - sz) >= 2;
    nd  = (d == 2'b01) ? 1 : (d == 2'b11) ? 2 : 0;
    err = (v != 2'b00 && !alw) || d == 2'b10 || nd > sz;
    nq  = mq;
    if (f) nq.delete();
    else begin
      if (d != 2'b10 && nd <= sz) repeat (nd) void'(nq.pop_front());
      if (alw) begin
        if (v[0]) nq.push_back(a);
        if (v[1]) nq.push_back(b);
      end
    end
    in_valid_i = v; in_data_i = {b, a}; deq_i = d; flush_i = f;
    @(posedge clk); #1;
    mq = nq; m_err = err;
    in_valid_i = 2'b00; in_data_i = '0; deq_i = 2'b00; flush_i = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mq.delete();
    m_err = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush_i = 1'b0; in_valid_i = 2'b00; deq_i = 2'b00; in_data_i = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk_on = 1'b1;
    check("rst_count",   64'(count_o), 64'd0);
    check("rst_allowin", 64'(allowin_o), 64'd1);
    check("rst_valid",   64'(out_valid_o), 64'd0);
    check("rst_afull",   64'(almost_full_o), 64'd0);
    check("rst_error",   64'(error_o), 64'd0);

    // First pair becomes visible one edge later.
    step(2'b11, 32'hA0, 32'hB0, 2'b00, 1'b0);
    check("t1_count",   64'(count_o), 64'd2);
    check("t1_valid",   64'(out_valid_o), 64'd3);
    check("t1_data",    64'(out_data_o), 64'h000000B0_000000A0);
    check("t1_allowin", 64'(allowin_o), 64'd1);

    // Fill to DEPTH, then an enqueue is rejected with an error pulse.
    for (int i = 1; i < 4; i++) step(2'b11, 32'h10 + 2*i, 32'h11 + 2*i, 2'b00, 1'b0);
    check("full_count",   64'(count_o), 64'd8);
    check("full_allowin", 64'(allowin_o), 64'd0);
    check("full_afull",   64'(almost_full_o), 64'd1);
    step(2'b01, 32'hEE, 32'h0, 2'b00, 1'b0);
    check("full_err",    64'(error_o), 64'd1);
    check("full_count2", 64'(count_o), 64'd8);
    step(2'b00, 0, 0, 2'b00, 1'b0);
    check("err_clear", 64'(error_o), 64'd0);
    step(2'b00, 0, 0, 2'b11, 1'b0);
    check("drain_head", 64'(out_data_o[DW-1:0]), 64'h12);
    repeat (3) step(2'b00, 0, 0, 2'b11, 1'b0);

    // Wrap around the end of the array.
    do_reset();
    for (int i = 0; i < 3; i++) step(2'b11, 32'h20 + 2*i, 32'h21 + 2*i, 2'b00, 1'b0);
    repeat (3) step(2'b00, 0, 0, 2'b11, 1'b0);
    for (int i = 0; i < 3; i++) step(2'b11, 32'h30 + 2*i, 32'h31 + 2*i, 2'b00, 1'b0);
    check("wrap_count", 64'(count_o), 64'd6);
    check("wrap_data",  64'(out_data_o), 64'h00000031_00000030);
    step(2'b01, 32'h36, 32'h0, 2'b00, 1'b0);
    check("cnt7_allowin", 64'(allowin_o), 64'd0);
    step(2'b11, 32'h37, 32'h38, 2'b00, 1'b0);
    check("cnt7_err", 64'(error_o), 64'd1);
    repeat (3) step(2'b00, 0, 0, 2'b11, 1'b0);
    step(2'b00, 0, 0, 2'b01, 1'b0);

    // Simultaneous enqueue and dequeue.
    do_reset();
    step(2'b11, 32'h40, 32'h41, 2'b00, 1'b0);
    step(2'b01, 32'h42, 32'h0, 2'b00, 1'b0);
    step(2'b11, 32'h43, 32'h44, 2'b01, 1'b0);
    check("sim_count", 64'(count_o), 64'd4);
    check("sim_data",  64'(out_data_o), 64'h00000042_00000041);

    // Flush beats the enqueue and dequeue in the same cycle.
    step(2'b01, 32'h45, 32'h0, 2'b00, 1'b0);
    step(2'b11, 32'h50, 32'h51, 2'b11, 1'b1);
    check("flush_count",   64'(count_o), 64'd0);
    check("flush_valid",   64'(out_valid_o), 64'd0);
    check("flush_allowin", 64'(allowin_o), 64'd1);

    // Illegal dequeue encodings and over-pop.
    step(2'b11, 32'h60, 32'h61, 2'b00, 1'b0);
    step(2'b01, 32'h62, 32'h0, 2'b00, 1'b0);
    step(2'b00, 0, 0, 2'b10, 1'b0);
    check("deq10_err",   64'(error_o), 64'd1);
    check("deq10_count", 64'(count_o), 64'd3);
    step(2'b11, 32'h63, 32'h64, 2'b10, 1'b0);
    check("deq10_enq", 64'(count_o), 64'd5);
    step(2'b00, 0, 0, 2'b00, 1'b1);
    step(2'b01, 32'h70, 32'h0, 2'b00, 1'b0);
    step(2'b00, 0, 0, 2'b11, 1'b0);
    check("over_err",   64'(error_o), 64'd1);
    check("over_count", 64'(count_o), 64'd1);
    step(2'b00, 0, 0, 2'b00, 1'b1);
    step(2'b10, 32'h71, 32'h72, 2'b00, 1'b0);
    check("lane1_head",  64'(out_data_o[DW-1:0]), 64'h72);
    check("lane1_count", 64'(count_o), 64'd1);

    // Reset with entries pending drops them all.
    step(2'b11, 32'h80, 32'h81, 2'b00, 1'b0);
    do_reset();
    check("midrst_count", 64'(count_o), 64'd0);
    check("midrst_valid", 64'(out_valid_o), 64'd0);

    @(negedge clk);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
